// File: rtl/tx_flow_sched.sv
// tx_flow_sched: per-flow TX scheduler; source arbiter, pending bitvectors and round-robin flow scanner.
// Optional TX_FLOW_SCHED_SRC0_PRIO_EN gives source 0 (timeout engine) strict priority over the others.
package tcp_pkg;
    localparam int MAX_TCP_FLOWS = 16;
    localparam int FLOWID_W = $clog2(MAX_TCP_FLOWS);
    typedef enum logic [1:0] {SC_NOP = 2'd0, SC_SET = 2'd1, SC_CLEAR = 2'd2} set_clear_e;
    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        set_clear_e          rt;
        set_clear_e          ack;
        set_clear_e          data;
    } sched_cmd_struct;
endpackage

module tx_flow_sched
    import tcp_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_SRC-1:0]                        i_src_cmd_val,
    input  logic [NUM_SRC*$bits(sched_cmd_struct)-1:0] i_src_cmd_data,
    output logic [NUM_SRC-1:0]                        o_src_cmd_rdy,
    output logic                                      o_sched_tx_req_val,
    output logic [FLOWID_W-1:0]                       o_sched_tx_req_flowid,
    output logic [2:0]                                o_sched_tx_req_pend,
    input  logic                                      i_tx_sched_req_rdy
);
    localparam int CMD_W = $bits(sched_cmd_struct);
    localparam int RR_W  = $clog2(NUM_SRC);

    typedef enum logic {SCAN, ISSUE} state_e;

    state_e                         r_state, w_state_nxt;
    logic [RR_W-1:0]                r_rr_ptr, w_rr_nxt, w_gnt;
    logic                           w_gnt_ok, w_adv;
    logic [FLOWID_W-1:0]            r_scan_idx, w_scan_nxt, w_scan_inc;
    logic [2:0]                     r_snap, w_snap_nxt, w_hit;
    logic [2:0][MAX_TCP_FLOWS-1:0]  r_pend, w_pend_nxt;
    sched_cmd_struct                w_cmd;
    set_clear_e                     w_op [3];
    logic                           w_hs;

    always_comb begin
        w_gnt_ok = 1'b0;
        w_gnt    = '0;
`ifdef TX_FLOW_SCHED_SRC0_PRIO_EN
        if (i_src_cmd_val[0]) begin
            w_gnt_ok = 1'b1;
        end else begin
            for (int k = 0; k < NUM_SRC-1; k++) begin
                int idx;
                idx = ((r_rr_ptr == '0) ? 1 : int'(r_rr_ptr)) + k;
                if (idx >= NUM_SRC) idx = idx - (NUM_SRC-1);
                if (!w_gnt_ok && i_src_cmd_val[idx]) begin
                    w_gnt_ok = 1'b1;
                    w_gnt    = RR_W'(idx);
                end
            end
        end
`else
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!w_gnt_ok && i_src_cmd_val[idx]) begin
                w_gnt_ok = 1'b1;
                w_gnt    = RR_W'(idx);
            end
        end
`endif
    end

`ifdef TX_FLOW_SCHED_SRC0_PRIO_EN
    assign w_adv = w_gnt_ok && (w_gnt != '0);
`else
    assign w_adv = w_gnt_ok;
`endif
    assign w_rr_nxt      = w_adv ? ((w_gnt == RR_W'(NUM_SRC-1)) ? '0 : w_gnt + 1'b1) : r_rr_ptr;
    assign o_src_cmd_rdy = (w_gnt_ok && !rst) ? (NUM_SRC'(1) << w_gnt) : '0;
    assign w_cmd         = i_src_cmd_data[w_gnt*CMD_W +: CMD_W];
    assign w_op[2]       = w_cmd.rt;
    assign w_op[1]       = w_cmd.ack;
    assign w_op[0]       = w_cmd.data;

    assign w_hit      = {r_pend[2][r_scan_idx], r_pend[1][r_scan_idx], r_pend[0][r_scan_idx]};
    assign w_hs       = (r_state == ISSUE) && i_tx_sched_req_rdy;
    assign w_scan_inc = (r_scan_idx == FLOWID_W'(MAX_TCP_FLOWS-1)) ? '0 : r_scan_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_scan_nxt  = r_scan_idx;
        w_snap_nxt  = r_snap;
        if (r_state == SCAN) begin
            if (|w_hit) begin
                w_state_nxt = ISSUE;
                w_snap_nxt  = w_hit;
            end else begin
                w_scan_nxt = w_scan_inc;
            end
        end else if (i_tx_sched_req_rdy) begin
            w_state_nxt = SCAN;
            w_scan_nxt  = w_scan_inc;
        end
    end

    // Command applied after the issue clear so a same-cycle SET survives.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int b = 0; b < 3; b++) begin
            if (w_hs && r_snap[b]) w_pend_nxt[b][r_scan_idx] = 1'b0;
            if (w_gnt_ok && w_op[b] == SC_SET) w_pend_nxt[b][w_cmd.flowid] = 1'b1;
            else if (w_gnt_ok && w_op[b] == SC_CLEAR) w_pend_nxt[b][w_cmd.flowid] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SCAN;
            r_rr_ptr   <= '0;
            r_scan_idx <= '0;
            r_snap     <= '0;
            r_pend     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_scan_idx <= w_scan_nxt;
            r_snap     <= w_snap_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    assign o_sched_tx_req_val    = (r_state == ISSUE);
    assign o_sched_tx_req_flowid = r_scan_idx;
    assign o_sched_tx_req_pend   = r_snap;
endmodule

// File: tb/tb_tx_flow_sched.sv
// tb_tx_flow_sched: arbitration vector table plus scoreboarded request sequences for tx_flow_sched.
module tb_tx_flow_sched;
    import tcp_pkg::*;
    localparam int NS = 3;
    localparam int CW = $bits(sched_cmd_struct);

    typedef struct {
        logic [NS-1:0] val;
        logic [NS-1:0] exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NS-1:0]       val = '0;
    logic [NS*CW-1:0]    data = '0;
    logic [NS-1:0]       rdy;
    logic                req_val;
    logic [FLOWID_W-1:0] req_fid;
    logic [2:0]          req_pend;
    logic                tx_rdy = 1'b0;

    int n_cmp = 0, n_err = 0, n_hs = 0, cyc = 0, hs_last = 0, hs_prev = 0;
    logic [FLOWID_W+2:0] sb_q[$];
    vec_t tbl [12];

    tx_flow_sched #(.NUM_SRC(NS)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_src_cmd_val        (val),
        .i_src_cmd_data       (data),
        .o_src_cmd_rdy        (rdy),
        .o_sched_tx_req_val   (req_val),
        .o_sched_tx_req_flowid(req_fid),
        .o_sched_tx_req_pend  (req_pend),
        .i_tx_sched_req_rdy   (tx_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every accepted request is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && req_val && tx_rdy) begin
            n_hs++;
            hs_prev = hs_last;
            hs_last = cyc;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_unexpected: got flow %0d pend %b expected none", req_fid, req_pend);
            end else begin
                chk("req", {req_fid, req_pend}, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int s, input int f, input set_clear_e r, input set_clear_e a, input set_clear_e d);
        sched_cmd_struct c;
        c.flowid = FLOWID_W'(f);
        c.rt     = r;
        c.ack    = a;
        c.data   = d;
        data[s*CW +: CW] = c;
    endtask

    task automatic send(input int s, input int f, input set_clear_e r, input set_clear_e a, input set_clear_e d);
        set_cmd(s, f, r, a, d);
        val    = '0;
        val[s] = 1'b1;
        @(negedge clk);
        chk("send_rdy", 32'(rdy), 32'(1) << s);
        tick();
        val = '0;
    endtask

    task automatic wait_val();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_val) break;
        end
        chk("req_val_seen", 32'(req_val), 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic quiet(input string nm);
        int n0;
        n0 = n_hs;
        repeat (40) @(negedge clk);
        chk(nm, n_hs - n0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
`ifdef TX_FLOW_SCHED_SRC0_PRIO_EN
        tbl = '{'{3'b111, 3'b001}, '{3'b111, 3'b001}, '{3'b111, 3'b001}, '{3'b111, 3'b001},
                '{3'b111, 3'b001}, '{3'b111, 3'b001}, '{3'b110, 3'b010}, '{3'b110, 3'b100},
                '{3'b000, 3'b000}, '{3'b100, 3'b100}, '{3'b011, 3'b001}, '{3'b101, 3'b001}};
`else
        tbl = '{'{3'b111, 3'b001}, '{3'b111, 3'b010}, '{3'b111, 3'b100}, '{3'b111, 3'b001},
                '{3'b111, 3'b010}, '{3'b111, 3'b100}, '{3'b110, 3'b010}, '{3'b110, 3'b100},
                '{3'b000, 3'b000}, '{3'b100, 3'b100}, '{3'b011, 3'b001}, '{3'b101, 3'b100}};
`endif
        for (int s = 0; s < NS; s++) set_cmd(s, s + 1, SC_NOP, SC_NOP, SC_NOP);
        val = '1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_val", 32'(req_val), 0);
        chk("rst_fid", 32'(req_fid), 0);
        chk("rst_pend", 32'(req_pend), 0);
        tick();
        rst = 1'b0;
        val = '0;

        for (int i = 0; i < 12; i++) begin
            val = tbl[i].val;
            @(negedge clk);
            chk($sformatf("arb%0d", i), 32'(rdy), 32'(tbl[i].exp));
            tick();
        end
        val = '0;

        tx_rdy = 1'b1;
        n0 = n_hs;
        sb_q.push_back({FLOWID_W'(5), 3'b010});
        send(1, 5, SC_NOP, SC_SET, SC_NOP);
        wait_drain();
        repeat (40) @(negedge clk);
        chk("single_count", n_hs - n0, 1);

        tick();
        tx_rdy = 1'b0;
        send(0, 2, SC_SET, SC_NOP, SC_SET);
        wait_val();
        for (int i = 0; i < 10; i++) begin
            chk("bp_val", 32'(req_val), 1);
            chk("bp_fid", 32'(req_fid), 2);
            chk("bp_pend", 32'(req_pend), 3'b101);
            tick();
            set_cmd(0, 2, SC_NOP, SC_NOP, SC_CLEAR);
            val = (i == 2) ? 3'b001 : 3'b000;
            @(negedge clk);
        end
        tick();
        sb_q.push_back({FLOWID_W'(2), 3'b101});
        tx_rdy = 1'b1;
        wait_drain();
        quiet("bp_flow2_clear");

        tick();
        tx_rdy = 1'b0;
        send(1, 7, SC_NOP, SC_NOP, SC_SET);
        wait_val();
        chk("col_fid", 32'(req_fid), 7);
        chk("col_pend", 32'(req_pend), 3'b001);
        tick();
        tx_rdy = 1'b1;
        set_cmd(2, 7, SC_NOP, SC_NOP, SC_SET);
        val = 3'b100;
        sb_q.push_back({FLOWID_W'(7), 3'b001});
        sb_q.push_back({FLOWID_W'(7), 3'b001});
        @(negedge clk);
        chk("col_rdy", 32'(rdy), 3'b100);
        tick();
        val = '0;
        wait_drain();
        quiet("col_no_third");

        tick();
        tx_rdy = 1'b0;
        send(0, MAX_TCP_FLOWS - 1, SC_SET, SC_NOP, SC_NOP);
        wait_val();
        chk("wrap_fid", 32'(req_fid), MAX_TCP_FLOWS - 1);
        tick();
        send(1, 0, SC_NOP, SC_SET, SC_NOP);
        sb_q.push_back({FLOWID_W'(MAX_TCP_FLOWS - 1), 3'b100});
        sb_q.push_back({FLOWID_W'(0), 3'b010});
        tx_rdy = 1'b1;
        wait_drain();
        chk("wrap_gap", hs_last - hs_prev, 2);
        quiet("wrap_done");

        tick();
        tx_rdy = 1'b0;
        send(2, 9, SC_SET, SC_NOP, SC_NOP);
        wait_val();
        tick();
        rst = 1'b1;
        set_cmd(0, 3, SC_SET, SC_SET, SC_SET);
        val = 3'b001;
        @(negedge clk);
        chk("rst_mid_rdy", 32'(rdy), 0);
        tick();
        rst = 1'b0;
        val = '0;
        @(negedge clk);
        chk("rst_mid_val", 32'(req_val), 0);
        chk("rst_mid_fid", 32'(req_fid), 0);
        chk("rst_mid_pend", 32'(req_pend), 0);
        tx_rdy = 1'b1;
        quiet("rst_mid_lost");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
